// File: rtl/audplay_controller_if.sv
// Peripheral bus bundle for the audio playback controller.
// Supplies default BUS_ACC_* encodings when the surrounding bus package does not.
`ifndef BUS_ACC_WIDTH
`define BUS_ACC_WIDTH 2
`endif
`ifndef BUS_ACC_1B
`define BUS_ACC_1B 2'd0
`endif
`ifndef BUS_ACC_2B
`define BUS_ACC_2B 2'd1
`endif
`ifndef BUS_ACC_4B
`define BUS_ACC_4B 2'd2
`endif

interface audplay_controller_if;
    logic [3:0]                addr;
    logic                      w_rb;
    logic [`BUS_ACC_WIDTH-1:0] acc;
    logic [31:0]               wdata;
    logic [31:0]               rdata;
    logic                      req;
    logic                      resp;
    logic                      fault;

    modport master (output addr, w_rb, acc, wdata, req, input rdata, resp, fault);
    modport slave  (input addr, w_rb, acc, wdata, req, output rdata, resp, fault);
endinterface

// File: rtl/audplay_controller.sv
// I2S-style playback: bus-written samples are buffered and serialised MSB-first in the ws-low slot.
// Define AUDPLAY_STEREO_EN to repeat each popped word in the ws-high slot.
`ifndef BUS_ACC_WIDTH
`define BUS_ACC_WIDTH 2
`endif
`ifndef BUS_ACC_4B
`define BUS_ACC_4B 2'd2
`endif

module audplay_controller #(
    parameter int PRIMARY_DIV = 26,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    audplay_controller_if.slave   bus,
    output logic                  sck,
    output logic                  ws,
    output logic                  sd
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int DW = (PRIMARY_DIV > 1) ? $clog2(PRIMARY_DIV) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_LOW, ST_HIGH} state_t;

    state_t        state, state_nxt;
    logic [5:0]    cnt, cnt_nxt;
    logic [DW-1:0] div_cnt;
    logic          tick;
    logic          load;

    logic [15:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] level;
    logic          full, empty, push, pop;

    logic          en;
    logic [3:0]    shift;
    logic          ovf, udr;
    logic          ovf_set, udr_set;
    logic [31:0]   sr;
    logic [23:0]   shreg;
    logic [23:0]   head_ext, slot_word;
    logic [3:0]    sh_eff;
    logic          slot_active;
    logic          sd_nxt;
    logic [4:0]    bit_pos;

    logic          is_dr, is_sr, is_cr, invalid, valid;
    logic          wr_dr, wr_cr, rd_sr;
    logic          unused_wdata;

    assign unused_wdata = ^bus.wdata[30:16];

    always_ff @(posedge clk) begin
        if (!rstn)
            div_cnt <= '0;
        else if (div_cnt == DW'(PRIMARY_DIV - 1))
            div_cnt <= '0;
        else
            div_cnt <= div_cnt + DW'(1);
    end

    assign tick = (div_cnt == '0);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= ST_IDLE;
            cnt   <= 6'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // IDLE is only visited after reset; LOW/HIGH then alternate forever.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        load      = 1'b0;
        if (tick) begin
            cnt_nxt = cnt + 6'd1;
            if (cnt == 6'd63) begin
                case (state)
                    ST_IDLE, ST_HIGH: begin
                        state_nxt = ST_LOW;
                        load      = 1'b1;
                    end
                    ST_LOW:  state_nxt = ST_HIGH;
                    default: state_nxt = ST_IDLE;
                endcase
            end
        end
    end

    assign sck = (state == ST_IDLE) | cnt[0];
    assign ws  = (state == ST_IDLE) | (state == ST_HIGH);

    assign is_dr   = (bus.addr == 4'd0);
    assign is_sr   = (bus.addr == 4'd4);
    assign is_cr   = (bus.addr == 4'd8);
    assign invalid = (bus.addr[1:0] != 2'd0) | (bus.acc != `BUS_ACC_4B) | (bus.addr == 4'd12)
                   | (bus.w_rb & is_sr) | (~bus.w_rb & (is_dr | is_cr));
    assign valid   = bus.req & ~invalid;
    assign wr_dr   = valid & bus.w_rb & is_dr;
    assign wr_cr   = valid & bus.w_rb & is_cr;
    assign rd_sr   = valid & ~bus.w_rb & is_sr;
    assign bus.fault = bus.req & invalid;

    assign full    = (level == LW'(FIFO_DEPTH));
    assign empty   = (level == '0);
    assign pop     = load & en & ~empty;
    assign push    = wr_dr & (~full | pop);
    assign ovf_set = wr_dr & full & ~pop;
    assign udr_set = load & en & empty;

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= bus.wdata[15:0];
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            en    <= 1'b0;
            shift <= 4'd0;
        end else if (wr_cr) begin
            en    <= bus.wdata[31];
            shift <= bus.wdata[3:0];
        end
    end

    // A set event on the capture edge keeps the flag, so no event is ever lost.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            ovf <= 1'b0;
            udr <= 1'b0;
        end else begin
            ovf <= ovf_set | (ovf & ~rd_sr);
            udr <= udr_set | (udr & ~rd_sr);
        end
    end

    assign sr = {ovf, udr, 6'd0, 8'(level), 14'd0, empty, full};

    always_ff @(posedge clk) begin
        if (!rstn) begin
            bus.resp  <= 1'b0;
            bus.rdata <= 32'd0;
        end else begin
            bus.resp <= valid;
            if (rd_sr)
                bus.rdata <= sr;
        end
    end

    assign sh_eff    = (shift > 4'd8) ? 4'd8 : shift;
    assign head_ext  = {{8{mem[rd_ptr][15]}}, mem[rd_ptr]};
    assign slot_word = head_ext << sh_eff;

    always_ff @(posedge clk) begin
        if (!rstn)
            shreg <= 24'd0;
        else if (load)
            shreg <= pop ? slot_word : 24'd0;
    end

`ifdef AUDPLAY_STEREO_EN
    assign slot_active = (state_nxt == ST_LOW) | (state_nxt == ST_HIGH);
`else
    assign slot_active = (state_nxt == ST_LOW);
`endif

    // Each bit occupies an even/odd count pair so it is stable across the sck rising edge.
    always_comb begin
        sd_nxt  = 1'b0;
        bit_pos = 5'd0;
        if (slot_active && (cnt_nxt >= 6'd2) && (cnt_nxt <= 6'd49)) begin
            bit_pos = 5'd23 - 5'((cnt_nxt - 6'd2) >> 1);
            sd_nxt  = shreg[bit_pos];
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn)
            sd <= 1'b0;
        else if (tick)
            sd <= sd_nxt;
    end
endmodule
